// File: rtl/share_encoder.sv
// share_encoder: collects four 32-bit plain words into a 128-bit block, masks
// it with 128*(d-1) fresh random bits and presents the d-share bitsliced
// result on a valid/ready output. The unmasked block only lives in buf_reg.
module share_encoder #(
    parameter int d = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [128*(d-1)-1:0] rnd_in,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    output logic [128*d-1:0]     sh_out,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        MASK    = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [1:0]         wcnt_reg;
    logic [31:0]        buf_reg [4];
    logic [127:0]       plain_block;
    logic [128*d-1:0]   sh_reg;
    logic [128*d-1:0]   sh_next;
    logic               word_accept;
    logic               rnd_accept;

    assign word_accept = in_ready && in_valid;
    assign rnd_accept  = rnd_ready && rnd_valid;
    assign sh_out      = sh_reg;

    genvar gi;

    // Word slot gi is block bytes 4*gi..4*gi+3, so slots concatenate directly.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_word
            assign plain_block[32*gi +: 32] = buf_reg[gi];

            // Capture the accepted word into its slot.
            always_ff @(posedge clk) begin
                if (rst) begin
                    buf_reg[gi] <= '0;
                end else if (word_accept && (wcnt_reg == 2'(gi))) begin
                    buf_reg[gi] <= in_data;
                end
            end
        end
    endgenerate

    // Global bit b = 8*byte+bit occupies sh_out[d*b +: d]; share 0 at the LSB
    // absorbs the plain bit, shares 1..d-1 are the raw random bits of b.
    generate
        for (gi = 0; gi < 128; gi++) begin : g_bit
            logic [d-2:0] rb;
            assign rb = rnd_in[(d-1)*gi +: (d-1)];
            assign sh_next[d*gi +: d] = {rb, plain_block[gi] ^ (^rb)};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs; each state owns exactly one interface.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        rnd_ready  = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && (wcnt_reg == 2'd3)) begin
                    state_next = MASK;
                end
            end
            MASK: begin
                rnd_ready = 1'b1;
                if (rnd_valid) begin
                    state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = COLLECT;
                end
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    // Word counter wraps naturally after slot 3; masked block registered on
    // the randomness handshake and held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_reg <= 2'd0;
            sh_reg   <= '0;
        end else begin
            if (word_accept) begin
                wcnt_reg <= wcnt_reg + 2'd1;
            end
            if (rnd_accept) begin
                sh_reg <= sh_next;
            end
        end
    end

endmodule

// File: tb/tb_share_encoder.sv
// Bench for share_encoder: a d=2 and a d=3 instance run in lockstep on the
// same data; blocks are pushed to a scoreboard when randomness is handed over
// and popped when the output handshake is observed.
module tb_share_encoder;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         out_ready;
    logic         rnd_valid;
    logic [127:0] rnd2;
    logic [255:0] rnd3;
    logic         in_ready2, rnd_ready2, out_valid2;
    logic         in_ready3, rnd_ready3, out_valid3;
    logic [255:0] sh2;
    logic [383:0] sh3;

    int total = 0;
    int bad   = 0;
    int rnd_xfers = 0;
    int blocks_pushed = 0;
    int blocks_seen = 0;

    typedef struct {
        logic [127:0] plain;
        logic [255:0] rnd;
    } blk_t;
    blk_t sb_q[$];

    logic [127:0] plain_cur;
    logic [255:0] last_sh2;

    always #5 clk = ~clk;

    share_encoder #(.d(2)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready2), .rnd_in(rnd2), .rnd_valid(rnd_valid),
        .rnd_ready(rnd_ready2), .sh_out(sh2), .out_valid(out_valid2),
        .out_ready(out_ready)
    );

    share_encoder #(.d(3)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready3), .rnd_in(rnd3), .rnd_valid(rnd_valid),
        .rnd_ready(rnd_ready3), .sh_out(sh3), .out_valid(out_valid3),
        .out_ready(out_ready)
    );

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference encoding straight from the share and randomness layouts.
    function automatic logic [383:0] encode(input int dd, input logic [127:0] p, input logic [255:0] r);
        logic [383:0] res;
        logic x;
        res = '0;
        for (int b = 0; b < 128; b++) begin
            x = p[b];
            for (int s = 1; s < dd; s++) begin
                res[dd*b+s] = r[(dd-1)*b+s-1];
                x = x ^ r[(dd-1)*b+s-1];
            end
            res[dd*b] = x;
        end
        return res;
    endfunction

    function automatic logic [127:0] recombine(input int dd, input logic [383:0] sh);
        logic [127:0] p;
        logic x;
        for (int b = 0; b < 128; b++) begin
            x = 1'b0;
            for (int s = 0; s < dd; s++) x = x ^ sh[dd*b+s];
            p[b] = x;
        end
        return p;
    endfunction

    // Scoreboard monitor and randomness-transfer counter.
    always @(negedge clk) begin
        blk_t e;
        if (rst === 1'b0) begin
            if (rnd_valid && rnd_ready3) rnd_xfers++;
            if (out_valid2 && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_empty", 384'(sb_q.size()), 384'(1));
                end else begin
                    e = sb_q.pop_front();
                    check("sh_d2", 384'(sh2), encode(2, e.plain, e.rnd));
                    check("sh_d3", sh3, encode(3, e.plain, e.rnd));
                    check("recomb_d2", 384'(recombine(2, 384'(sh2))), 384'(e.plain));
                    check("recomb_d3", 384'(recombine(3, sh3)), 384'(e.plain));
                    blocks_seen++;
                    $display("block %0d plain=%h", blocks_seen, e.plain);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input logic [31:0] w, input int gap);
        int n;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 32'hFFFF_FFFF;
            step();
        end
        in_valid = 1'b1;
        in_data  = w;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready2) break;
            step();
        end
        if (n == 20) check("in_ready_timeout", 384'(0), 384'(1));
        else check("rnd_ready_collect", 384'(rnd_ready2), 384'(0));
        step();
        in_valid = 1'b0;
    endtask

    task automatic give_rnd(input logic [255:0] r, input int dly, input bit junk, input bit lat);
        int n;
        for (int i = 0; i < dly; i++) begin
            rnd_valid = 1'b0;
            if (junk) begin
                in_valid = 1'b1;
                in_data  = 32'hBAD0_BAD0;
            end
            @(negedge clk);
            check("rnd_ready_wait", 384'(rnd_ready2), 384'(1));
            check("in_ready_mask", 384'(in_ready2), 384'(0));
            step();
        end
        rnd_valid = 1'b1;
        rnd2 = r[127:0];
        rnd3 = r;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rnd_ready2) break;
            step();
        end
        if (n == 20) begin
            check("rnd_ready_timeout", 384'(0), 384'(1));
        end else begin
            if (lat) check("rnd_latency", 384'(n), 384'(0));
            check("out_valid_mask", 384'(out_valid2), 384'(0));
            sb_q.push_back('{plain: plain_cur, rnd: r});
            blocks_pushed++;
        end
        step();
        rnd2 = {$urandom, $urandom, $urandom, $urandom};
        rnd3 = {rnd2, rnd2};
        rnd_valid = junk;
    endtask

    task automatic take_out(input int dly, input bit lat);
        int n;
        int k;
        bit done;
        logic [255:0] held;
        k = 0;
        done = 1'b0;
        held = '0;
        out_ready = (dly == 0);
        for (n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (out_valid2) begin
                if (k == 0) begin
                    held = sh2;
                    if (lat) check("out_latency", 384'(n), 384'(0));
                end else begin
                    check("sh_stable", 384'(sh2), 384'(held));
                end
                check("in_ready_output", 384'(in_ready2), 384'(0));
                last_sh2 = sh2;
                if (out_ready) done = 1'b1;
                k++;
            end
            step();
            if (k >= dly && k > 0) out_ready = 1'b1;
        end
        if (!done) check("out_timeout", 384'(0), 384'(1));
        out_ready = 1'b0;
        in_valid  = 1'b0;
        rnd_valid = 1'b0;
        @(negedge clk);
        check("out_valid_drop", 384'(out_valid2), 384'(0));
        check("in_ready_back", 384'(in_ready2), 384'(1));
        step();
    endtask

    task automatic send_block(input logic [127:0] p, input logic [255:0] r, input int gap,
                              input int rdly, input int odly, input bit junk, input bit lat);
        plain_cur = p;
        if (lat) begin
            rnd_valid = 1'b1;
            rnd2 = r[127:0];
            rnd3 = r;
        end
        for (int i = 0; i < 4; i++) put_word(p[32*i +: 32], (i == 0) ? 0 : gap);
        give_rnd(r, rdly, junk, lat);
        take_out(odly, lat);
    endtask

    typedef struct {
        logic [127:0] plain;
        logic [255:0] rnd;
        int           gap;
        int           rdly;
        int           odly;
        bit           junk;
        bit           lat;
        logic [127:0] s0;
        logic [127:0] s1;
    } vec_t;

    localparam logic [127:0] PLAIN_A = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] PLAIN_B = 128'hDDEEFF00_99AABBCC_55667788_11223344;

    initial begin
        vec_t vecs [4];
        logic [127:0] s0;
        logic [127:0] s1;
        logic [255:0] r;

        vecs[0] = '{PLAIN_A, '0, 0, 0, 0, 1'b0, 1'b1, PLAIN_A, '0};
        vecs[1] = '{PLAIN_A, {128'h0, {128{1'b1}}}, 0, 0, 0, 1'b0, 1'b0,
                    128'hF0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFEFF, {128{1'b1}}};
        vecs[2] = '{PLAIN_A, {128'h0, {16{8'hA5}}}, 0, 5, 7, 1'b1, 1'b0,
                    128'hAAABA8A9_AEAFACAD_A2A3A0A1_A6A7A4A5, {16{8'hA5}}};
        vecs[3] = '{PLAIN_B, '0, 1, 0, 0, 1'b0, 1'b0, PLAIN_B, '0};

        rst = 1'b1;
        in_data = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        rnd_valid = 1'b0;
        rnd2 = '0;
        rnd3 = '0;
        last_sh2 = '0;
        plain_cur = '0;
        step();
        step();
        @(negedge clk);
        check("rst_in_ready", 384'(in_ready2), 384'(1));
        check("rst_rnd_ready", 384'(rnd_ready2), 384'(0));
        check("rst_out_valid", 384'(out_valid2), 384'(0));
        check("rst_sh_d2", 384'(sh2), 384'(0));
        check("rst_sh_d3", sh3, 384'(0));
        step();
        rst = 1'b0;

        // Table-driven d=2 vectors with explicit per-share expectations.
        for (int v = 0; v < 4; v++) begin
            send_block(vecs[v].plain, vecs[v].rnd, vecs[v].gap, vecs[v].rdly,
                       vecs[v].odly, vecs[v].junk, vecs[v].lat);
            for (int b = 0; b < 128; b++) begin
                s0[b] = last_sh2[2*b];
                s1[b] = last_sh2[2*b+1];
            end
            check($sformatf("vec%0d_share0", v), 384'(s0), 384'(vecs[v].s0));
            check($sformatf("vec%0d_share1", v), 384'(s1), 384'(vecs[v].s1));
        end

        // Reset after two words: partial block discarded, counter restarts.
        put_word(32'hCAFEF00D, 0);
        put_word(32'h12345678, 0);
        rst = 1'b1;
        rnd_valid = 1'b1;
        step();
        rst = 1'b0;
        rnd_valid = 1'b0;
        @(negedge clk);
        check("rst2w_out_valid", 384'(out_valid2), 384'(0));
        check("rst2w_rnd_ready", 384'(rnd_ready2), 384'(0));
        check("rst2w_sh", 384'(sh2), 384'(0));
        check("rst2w_in_ready", 384'(in_ready2), 384'(1));
        step();
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        send_block(128'h00112233_44556677_8899AABB_CCDDEEFF, r, 0, 0, 0, 1'b0, 1'b0);

        // Reset while an output is pending: the block is dropped.
        plain_cur = PLAIN_B;
        for (int i = 0; i < 4; i++) put_word(PLAIN_B[32*i +: 32], 0);
        give_rnd({256{1'b1}}, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_rst_out_valid", 384'(out_valid2), 384'(1));
        step();
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check("rstout_out_valid", 384'(out_valid2), 384'(0));
        check("rstout_rnd_ready", 384'(rnd_ready2), 384'(0));
        check("rstout_sh_d2", 384'(sh2), 384'(0));
        check("rstout_sh_d3", sh3, 384'(0));
        step();
        send_block(PLAIN_A, {256{1'b1}}, 0, 1, 1, 1'b0, 1'b0);

        // Random blocks on both instances with random handshake timing.
        for (int k = 0; k < 100; k++) begin
            r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            send_block({$urandom, $urandom, $urandom, $urandom}, r,
                       int'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                       int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0);
        end

        check("rnd_transfers", 384'(rnd_xfers), 384'(blocks_pushed));
        check("sb_drained", 384'(sb_q.size()), 384'(0));
        check("blocks_out", 384'(blocks_seen), 384'(blocks_pushed - 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
